// File: rtl/seg_display_arbiter.sv
// Arbitrates the shared 4-digit seven-segment scanner between the CPU MMIO writer and the debug source.
// Round-robin on ties, bounded tenure while contested, and a hold window after release so values stay readable.
module seg_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned MAX_OWN     = 4000,
    parameter int unsigned CW          = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_data,
    output logic        cpu_gnt,
    input  logic        dbg_req,
    input  logic [15:0] dbg_data,
    output logic        dbg_gnt,
    output logic [15:0] disp_data,
    output logic        disp_load,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DBG, HOLD} state_t;

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] OWN_LAST  = CW'((MAX_OWN == 0) ? 0 : MAX_OWN - 1);
    localparam bit            PREEMPT   = (MAX_OWN != 0);

    state_t        state;
    logic          last_dbg;
    logic [CW-1:0] ten_cnt;
    logic [CW-1:0] hold_cnt;
    logic          pick_cpu;
    logic          pick_dbg;
    logic          hold_done;
    logic          ten_hit;

    // last_dbg=1 means debug owned last, so the CPU wins the next tie
    assign pick_cpu  = cpu_req & (~dbg_req | last_dbg);
    assign pick_dbg  = dbg_req & ~pick_cpu;
    assign hold_done = (hold_cnt == HOLD_LAST);
    assign ten_hit   = PREEMPT && (ten_cnt == OWN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cpu_gnt   <= 1'b0;
            dbg_gnt   <= 1'b0;
            disp_data <= 16'h0000;
            disp_load <= 1'b0;
            owner     <= 2'b00;
            last_dbg  <= 1'b1;
            ten_cnt   <= '0;
            hold_cnt  <= '0;
        end else begin
            disp_load <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (state == HOLD && hold_cnt != CNT_MAX)
                        hold_cnt <= hold_cnt + 1'b1;
                    // The releasing owner may come straight back; the value is only reloaded if it changed
                    if (state == HOLD && !last_dbg && cpu_req) begin
                        state   <= OWN_CPU;
                        cpu_gnt <= 1'b1;
                        owner   <= 2'b01;
                        ten_cnt <= '0;
                        if (cpu_data != disp_data) begin
                            disp_data <= cpu_data;
                            disp_load <= 1'b1;
                        end
                    end else if (state == HOLD && last_dbg && dbg_req) begin
                        state   <= OWN_DBG;
                        dbg_gnt <= 1'b1;
                        owner   <= 2'b10;
                        ten_cnt <= '0;
                        if (dbg_data != disp_data) begin
                            disp_data <= dbg_data;
                            disp_load <= 1'b1;
                        end
                    end else if (state == IDLE || hold_done) begin
                        if (pick_cpu) begin
                            state     <= OWN_CPU;
                            cpu_gnt   <= 1'b1;
                            owner     <= 2'b01;
                            last_dbg  <= 1'b0;
                            ten_cnt   <= '0;
                            disp_data <= cpu_data;
                            disp_load <= 1'b1;
                        end else if (pick_dbg) begin
                            state     <= OWN_DBG;
                            dbg_gnt   <= 1'b1;
                            owner     <= 2'b10;
                            last_dbg  <= 1'b1;
                            ten_cnt   <= '0;
                            disp_data <= dbg_data;
                            disp_load <= 1'b1;
                        end else begin
                            state <= IDLE;
                            owner <= 2'b00;
                        end
                    end
                end
                OWN_CPU: begin
                    // Release is checked first so it beats a coincident preemption
                    if (!cpu_req) begin
                        state    <= HOLD;
                        cpu_gnt  <= 1'b0;
                        owner    <= 2'b11;
                        hold_cnt <= '0;
                    end else if (ten_hit && dbg_req) begin
                        state     <= OWN_DBG;
                        cpu_gnt   <= 1'b0;
                        dbg_gnt   <= 1'b1;
                        owner     <= 2'b10;
                        last_dbg  <= 1'b1;
                        ten_cnt   <= '0;
                        disp_data <= dbg_data;
                        disp_load <= 1'b1;
                    end else begin
                        if (cpu_data != disp_data) begin
                            disp_data <= cpu_data;
                            disp_load <= 1'b1;
                        end
                        if (dbg_req && ten_cnt != CNT_MAX)
                            ten_cnt <= ten_cnt + 1'b1;
                    end
                end
                OWN_DBG: begin
                    if (!dbg_req) begin
                        state    <= HOLD;
                        dbg_gnt  <= 1'b0;
                        owner    <= 2'b11;
                        hold_cnt <= '0;
                    end else if (ten_hit && cpu_req) begin
                        state     <= OWN_CPU;
                        dbg_gnt   <= 1'b0;
                        cpu_gnt   <= 1'b1;
                        owner     <= 2'b01;
                        last_dbg  <= 1'b0;
                        ten_cnt   <= '0;
                        disp_data <= cpu_data;
                        disp_load <= 1'b1;
                    end else begin
                        if (dbg_data != disp_data) begin
                            disp_data <= dbg_data;
                            disp_load <= 1'b1;
                        end
                        if (cpu_req && ten_cnt != CNT_MAX)
                            ten_cnt <= ten_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cpu_gnt <= 1'b0;
                    dbg_gnt <= 1'b0;
                    owner   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter with short hold/tenure windows.
// Expected display loads are queued as stimulus is driven and matched against each disp_load pulse.
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_data = 16'h0000;
    logic        cpu_gnt;
    logic        dbg_req = 1'b0;
    logic [15:0] dbg_data = 16'h0000;
    logic        dbg_gnt;
    logic [15:0] disp_data;
    logic        disp_load;
    logic [1:0]  owner;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] exp_q[$];

    seg_display_arbiter #(
        .HOLD_CYCLES(5),
        .MAX_OWN    (8),
        .CW         (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_data (cpu_data),
        .cpu_gnt  (cpu_gnt),
        .dbg_req  (dbg_req),
        .dbg_data (dbg_data),
        .dbg_gnt  (dbg_gnt),
        .disp_data(disp_data),
        .disp_load(disp_load),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c_req, input logic [15:0] c_data,
                                 input logic d_req, input logic [15:0] d_data);
        cpu_req  = c_req;
        cpu_data = c_data;
        dbg_req  = d_req;
        dbg_data = d_data;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    // Scoreboard: every load pulse must match the oldest queued value; grants are never shared
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("gnt_exclusive", {31'h0, cpu_gnt & dbg_gnt}, 32'h0);
            if (disp_load) begin
                checkOutput("load_expected", {31'h0, exp_q.size() != 0}, 32'h1);
                if (exp_q.size() != 0)
                    checkOutput("load_data", {16'h0, disp_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        step();
        checkOutput("rst_cpu_gnt", {31'h0, cpu_gnt}, 32'h0);
        checkOutput("rst_dbg_gnt", {31'h0, dbg_gnt}, 32'h0);
        checkOutput("rst_disp",    {16'h0, disp_data}, 32'h0);
        checkOutput("rst_load",    {31'h0, disp_load}, 32'h0);
        checkOutput("rst_owner",   {30'h0, owner}, 32'h0);

        // Single CPU request, then data updates including a repeat
        applyReset();
        applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0000);
        exp_q.push_back(16'h1234);
        step();
        checkOutput("t1_cpu_gnt", {31'h0, cpu_gnt}, 32'h1);
        checkOutput("t1_owner",   {30'h0, owner}, 32'h1);
        checkOutput("t1_disp",    {16'h0, disp_data}, 32'h1234);
        applyStimulus(1'b1, 16'h00AA, 1'b0, 16'h0000);
        exp_q.push_back(16'h00AA);
        step();
        checkOutput("t5_disp_aa", {16'h0, disp_data}, 32'h00AA);
        step();
        checkOutput("t5_repeat_load", {31'h0, disp_load}, 32'h0);
        applyStimulus(1'b1, 16'h00BB, 1'b0, 16'h0000);
        exp_q.push_back(16'h00BB);
        step();
        checkOutput("t5_disp_bb", {16'h0, disp_data}, 32'h00BB);
        step();
        checkOutput("t5_pending", exp_q.size(), 32'h0);
        applyStimulus(1'b0, 16'h00BB, 1'b0, 16'h0000);
        step();
        checkOutput("hold_owner", {30'h0, owner}, 32'h3);
        checkOutput("hold_gnt",   {31'h0, cpu_gnt}, 32'h0);
        applyStimulus(1'b1, 16'h00BB, 1'b0, 16'h0000);
        step();
        checkOutput("resume_gnt",   {31'h0, cpu_gnt}, 32'h1);
        checkOutput("resume_owner", {30'h0, owner}, 32'h1);
        step();
        checkOutput("resume_pending", exp_q.size(), 32'h0);

        // Tie after reset goes to CPU; debug waits out the full hold window
        applyReset();
        applyStimulus(1'b1, 16'h1111, 1'b1, 16'h2222);
        exp_q.push_back(16'h1111);
        step();
        checkOutput("t2_cpu_gnt", {31'h0, cpu_gnt}, 32'h1);
        checkOutput("t2_dbg_gnt", {31'h0, dbg_gnt}, 32'h0);
        applyStimulus(1'b0, 16'h1111, 1'b1, 16'h2222);
        step();
        checkOutput("t4_hold_owner", {30'h0, owner}, 32'h3);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("t4_dbg_wait", {31'h0, dbg_gnt}, 32'h0);
            checkOutput("t4_disp_kept", {16'h0, disp_data}, 32'h1111);
        end
        exp_q.push_back(16'h2222);
        step();
        checkOutput("t4_dbg_gnt", {31'h0, dbg_gnt}, 32'h1);
        checkOutput("t4_owner",   {30'h0, owner}, 32'h2);
        checkOutput("t4_disp",    {16'h0, disp_data}, 32'h2222);
        step();
        checkOutput("t4_pending", exp_q.size(), 32'h0);

        // Contested CPU tenure is preempted after MAX_OWN cycles
        applyReset();
        applyStimulus(1'b1, 16'h3333, 1'b0, 16'h0000);
        exp_q.push_back(16'h3333);
        step();
        checkOutput("t3_cpu_gnt", {31'h0, cpu_gnt}, 32'h1);
        applyStimulus(1'b1, 16'h3333, 1'b1, 16'h4444);
        for (int i = 0; i < 7; i++) begin
            step();
            checkOutput("t3_dbg_wait", {31'h0, dbg_gnt}, 32'h0);
            checkOutput("t3_cpu_kept", {31'h0, cpu_gnt}, 32'h1);
        end
        exp_q.push_back(16'h4444);
        step();
        checkOutput("t3_dbg_gnt", {31'h0, dbg_gnt}, 32'h1);
        checkOutput("t3_cpu_drop", {31'h0, cpu_gnt}, 32'h0);
        checkOutput("t3_owner", {30'h0, owner}, 32'h2);
        checkOutput("t3_disp", {16'h0, disp_data}, 32'h4444);
        applyStimulus(1'b0, 16'h3333, 1'b1, 16'h4444);
        step();
        checkOutput("t3_pending", exp_q.size(), 32'h0);

        // Asynchronous reset while debug owns the display
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_cpu_gnt", {31'h0, cpu_gnt}, 32'h0);
        checkOutput("t6_dbg_gnt", {31'h0, dbg_gnt}, 32'h0);
        checkOutput("t6_disp",    {16'h0, disp_data}, 32'h0);
        checkOutput("t6_owner",   {30'h0, owner}, 32'h0);
        checkOutput("t6_load",    {31'h0, disp_load}, 32'h0);
        applyReset();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
